// File: rtl/ls_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache (one doubleword per line).
// A single request is in flight at a time; misses and all stores go to memory over a valid/ready channel.
module ls_dcache #(
   parameter int XLEN  = 64,
   parameter int SETS  = 16,
   parameter int IDX_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inv,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wen,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [7:0]      req_wmask,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic            mem_req_wen,
   output logic [XLEN-1:0] mem_req_addr,
   output logic [XLEN-1:0] mem_req_wdata,
   output logic [7:0]      mem_req_wmask,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_rdata,
   output logic [31:0]     hit_cnt,
   output logic [31:0]     miss_cnt
);
   localparam int DW_W  = XLEN - 3;
   localparam int TAG_W = XLEN - IDX_W - 3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_WR_REQ, S_WR_WAIT
   } state_t;

   state_t                 state_q, state_d;
   logic                   wen_q, wen_d;
   logic [DW_W-1:0]        addr_q, addr_d;
   logic [XLEN-1:0]        wdata_q, wdata_d;
   logic [7:0]             wmask_q, wmask_d;
   logic [SETS-1:0]        valid_q, valid_d;
   logic [TAG_W-1:0]       tag_q  [SETS];
   logic [TAG_W-1:0]       tag_d  [SETS];
   logic [XLEN-1:0]        data_q [SETS];
   logic [XLEN-1:0]        data_d [SETS];
   logic                   inv_pend_q, inv_pend_d;
   logic [31:0]            hit_cnt_q, hit_cnt_d;
   logic [31:0]            miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0]       idx;
   logic [TAG_W-1:0]       tag;
   logic                   line_hit;
   logic                   unused_addr_lsb;

   assign unused_addr_lsb = ^req_addr[2:0];
   assign idx      = addr_q[IDX_W-1:0];
   assign tag      = addr_q[DW_W-1:IDX_W];
   assign line_hit = valid_q[idx] && (tag_q[idx] == tag);
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   always_comb begin
      state_d       = state_q;
      wen_d         = wen_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      valid_d       = valid_q;
      tag_d         = tag_q;
      data_d        = data_q;
      inv_pend_d    = inv_pend_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      mem_req_valid = 1'b0;
      mem_req_wen   = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;

      if (inv && state_q != S_IDLE) inv_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (inv || inv_pend_q) begin
               valid_d    = '0;
               inv_pend_d = 1'b0;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  wen_d   = req_wen;
                  addr_d  = req_addr[XLEN-1:3];
                  wdata_d = req_wdata;
                  wmask_d = req_wmask;
                  state_d = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (!wen_q) begin
               if (line_hit) begin
                  resp_valid = 1'b1;
                  resp_rdata = data_q[idx];
                  hit_cnt_d  = hit_cnt_q + 32'd1;
                  state_d    = S_IDLE;
               end else begin
                  miss_cnt_d = miss_cnt_q + 32'd1;
                  state_d    = S_MISS_REQ;
               end
            end else begin
               // write-through: keep a resident copy coherent, never allocate on a store miss
               if (line_hit) begin
                  for (int b = 0; b < 8; b++) begin
                     if (wmask_q[b]) data_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
               state_d = S_WR_REQ;
            end
         end
         S_MISS_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {addr_q, 3'b000};
            if (mem_req_ready) state_d = S_MISS_WAIT;
         end
         S_MISS_WAIT: begin
            if (mem_resp_valid) begin
               data_d[idx]  = mem_resp_rdata;
               tag_d[idx]   = tag;
               valid_d[idx] = 1'b1;
               resp_valid   = 1'b1;
               resp_rdata   = mem_resp_rdata;
               state_d      = S_IDLE;
            end
         end
         S_WR_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_wen   = 1'b1;
            mem_req_addr  = {addr_q, 3'b000};
            mem_req_wdata = wdata_q;
            mem_req_wmask = wmask_q;
            if (mem_req_ready) state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (mem_resp_valid) begin
               resp_valid = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // outputs must read idle for the whole time reset is held, not just after the next edge
      if (rst) begin
         req_ready     = 1'b0;
         resp_valid    = 1'b0;
         resp_rdata    = '0;
         mem_req_valid = 1'b0;
         mem_req_wen   = 1'b0;
         mem_req_addr  = '0;
         mem_req_wdata = '0;
         mem_req_wmask = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         valid_q    <= '0;
         tag_q      <= '{default: '0};
         data_q     <= '{default: '0};
         inv_pend_q <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         inv_pend_q <= inv_pend_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_ls_dcache.sv
// Directed bench for ls_dcache: the bench plays both the LSU and the memory side cycle by cycle.
module tb_ls_dcache;
   logic        clk = 1'b0;
   logic        rst, inv;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic [31:0] hit_cnt, miss_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   ls_dcache #(.XLEN(64), .SETS(16), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .inv(inv),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
   endtask

   // miss path: memory answers on the second cycle after the request handshake
   task automatic load_op(input logic [63:0] addr, input bit hit, input logic [63:0] exp,
                          input bit inv_at_fill);
      wait_ready();
      req_valid = 1'b1; req_wen = 1'b0; req_addr = addr;
      step();
      req_valid = 1'b0;
      if (hit) begin
         chk("hit_resp_valid", {63'd0, resp_valid}, 64'd1);
         chk("hit_rdata", resp_rdata, exp);
         chk("hit_no_mem", {63'd0, mem_req_valid}, 64'd0);
         step();
         return;
      end
      chk("miss_lookup_resp", {63'd0, resp_valid}, 64'd0);
      step();
      chk("miss_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("miss_mem_wen", {63'd0, mem_req_wen}, 64'd0);
      chk("miss_mem_addr", mem_req_addr, {addr[63:3], 3'b000});
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("miss_wait_idle", {62'd0, mem_req_valid, resp_valid}, 64'd0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = exp; inv = inv_at_fill;
      #1;
      chk("fill_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("fill_rdata", resp_rdata, exp);
      step();
      mem_resp_valid = 1'b0; mem_resp_rdata = '0; inv = 1'b0;
   endtask

   task automatic store_op(input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask,
                           input int stall, input bit do_rst);
      wait_ready();
      req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
      step();
      req_valid = 1'b0; req_wen = 1'b0;
      chk("st_lookup_quiet", {62'd0, mem_req_valid, resp_valid}, 64'd0);
      step();
      for (int i = 0; i <= stall; i++) begin
         chk("st_mem_valid", {63'd0, mem_req_valid}, 64'd1);
         chk("st_mem_wen", {63'd0, mem_req_wen}, 64'd1);
         chk("st_mem_addr", mem_req_addr, {addr[63:3], 3'b000});
         chk("st_mem_wdata", mem_req_wdata, wdata);
         chk("st_mem_wmask", {56'd0, mem_req_wmask}, {56'd0, wmask});
         if (i == stall) mem_req_ready = 1'b1;
         step();
      end
      mem_req_ready = 1'b0;
      chk("st_wait_no_req", {63'd0, mem_req_valid}, 64'd0);
      step();
      mem_resp_valid = 1'b1;
      #1;
      chk("st_ack_valid", {63'd0, resp_valid}, 64'd1);
      chk("st_ack_rdata", resp_rdata, 64'd0);
      if (do_rst) begin
         rst = 1'b1;
         #1;
         chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
         chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
         chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
         chk("rst_mem_wdata", mem_req_wdata, 64'd0);
         step();
         rst = 1'b0;
         #1;
         chk("late_resp_ignored", {63'd0, resp_valid}, 64'd0);
         chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
         chk("post_rst_hits", {32'd0, hit_cnt}, 64'd0);
         chk("post_rst_misses", {32'd0, miss_cnt}, 64'd0);
      end
      step();
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; inv = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      #1;
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_outputs", {62'd0, resp_valid, mem_req_valid}, 64'd0);
      chk("rst_mem_addr", mem_req_addr, 64'd0);
      chk("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
      step(); step();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

      load_op(64'h8000_0010, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
      chk("miss_cnt_1", {32'd0, miss_cnt}, 64'd1);
      load_op(64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 1'b0);
      chk("hit_cnt_1", {32'd0, hit_cnt}, 64'd1);

      store_op(64'h8000_0010, 64'h0000_0000_AABB_CCDD, 8'h0F, 0, 1'b0);
      load_op(64'h8000_0010, 1'b1, 64'h1122_3344_AABB_CCDD, 1'b0);
      chk("cnts_after_store", {hit_cnt, miss_cnt}, {32'd2, 32'd1});

      load_op(64'h8000_0090, 1'b0, 64'hDEAD_0000_BEEF_0090, 1'b0);
      load_op(64'h8000_0010, 1'b0, 64'h1122_3344_AABB_CCDD, 1'b0);
      chk("conflict_misses", {32'd0, miss_cnt}, 64'd3);

      store_op(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 1'b0);
      load_op(64'h8000_0017, 1'b1, 64'h1122_3344_AABB_CCDD, 1'b0);

      load_op(64'h8000_0018, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
      load_op(64'h8000_0010, 1'b1, 64'h1122_3344_AABB_CCDD, 1'b0);
      chk("cnts_mid", {hit_cnt, miss_cnt}, {32'd4, 32'd4});

      load_op(64'h8000_0090, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);
      #1;
      chk("inv_ready_low", {63'd0, req_ready}, 64'd0);
      step();
      chk("inv_ready_back", {63'd0, req_ready}, 64'd1);
      load_op(64'h8000_0090, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
      load_op(64'h8000_0018, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
      chk("cnts_after_inv", {hit_cnt, miss_cnt}, {32'd4, 32'd7});

      store_op(64'h8000_0090, 64'h5555_6666_7777_8888, 8'hF0, 5, 1'b1);
      load_op(64'h8000_0090, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
      chk("cnts_after_rst", {hit_cnt, miss_cnt}, {32'd0, 32'd1});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
